// File: rtl/pipe_tx_data.sv
// PIPE MAC-side transmit datapath: width masking, 128b/130b block framing and
// the once-per-64-beat gearbox stall. All PHY-facing Tx outputs are registered.
module pipe_tx_data #(
  parameter int GEN1_PIPEWIDTH = 8,
  parameter int GEN2_PIPEWIDTH = 16,
  parameter int GEN3_PIPEWIDTH = 32,
  parameter int GEN4_PIPEWIDTH = 8,
  parameter int GEN5_PIPEWIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  GEN,
  input  logic [31:0] MACData,
  input  logic [3:0]  MACDataK,
  input  logic        MACDataValid,
  input  logic [1:0]  MACSyncHeader,
  input  logic        MACElectricalIdle,
  output logic        MACReady,
  output logic [31:0] TxData,
  output logic [3:0]  TxDataK,
  output logic        TxDataValid,
  output logic        TxStartBlock,
  output logic [1:0]  TxSyncHeader,
  output logic        TxElectricalIdle,
  output logic [5:0]  PIPEWIDTH
);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_8B    = 2'd1,
    S_130   = 2'd2,
    S_STALL = 2'd3
  } state_t;

  state_t      state_r;
  logic [2:0]  gen_q_r;
  logic [4:0]  beat_cnt_r;
  logic [4:0]  block_cnt_r;

  logic [5:0]  width_s;
  logic [31:0] data_mask_s;
  logic [3:0]  k_mask_s;
  logic [4:0]  last_beat_s;
  logic [4:0]  last_block_s;
  logic        gen_chg_s;
  logic        accept_s;

  function automatic state_t gen_state_f(input logic [2:0] gen);
    state_t st;
    case (gen)
      3'd1, 3'd2:       st = S_8B;
      3'd3, 3'd4, 3'd5: st = S_130;
      default:          st = S_OFF;
    endcase
    return st;
  endfunction

  // Per-rate PIPE width and the derived masks and block/period limits.
  always_comb begin
    width_s      = 6'd0;
    data_mask_s  = 32'h0000_0000;
    k_mask_s     = 4'h0;
    last_beat_s  = 5'd0;
    last_block_s = 5'd0;
    case (GEN)
      3'd1:    width_s = 6'(GEN1_PIPEWIDTH);
      3'd2:    width_s = 6'(GEN2_PIPEWIDTH);
      3'd3:    width_s = 6'(GEN3_PIPEWIDTH);
      3'd4:    width_s = 6'(GEN4_PIPEWIDTH);
      3'd5:    width_s = 6'(GEN5_PIPEWIDTH);
      default: width_s = 6'd0;
    endcase
    // B = 128/W beats per block, N = W/2 blocks per stall period.
    case (width_s)
      6'd8: begin
        data_mask_s  = 32'h0000_00FF;
        k_mask_s     = 4'h1;
        last_beat_s  = 5'd15;
        last_block_s = 5'd3;
      end
      6'd16: begin
        data_mask_s  = 32'h0000_FFFF;
        k_mask_s     = 4'h3;
        last_beat_s  = 5'd7;
        last_block_s = 5'd7;
      end
      6'd32: begin
        data_mask_s  = 32'hFFFF_FFFF;
        k_mask_s     = 4'hF;
        last_beat_s  = 5'd3;
        last_block_s = 5'd15;
      end
      default: begin
        data_mask_s  = 32'h0000_0000;
        k_mask_s     = 4'h0;
        last_beat_s  = 5'd0;
        last_block_s = 5'd0;
      end
    endcase
  end

  assign PIPEWIDTH = width_s;
  assign gen_chg_s = (GEN != gen_q_r);
  assign MACReady  = ((state_r == S_8B) || (state_r == S_130)) &&
                     !MACElectricalIdle && !gen_chg_s;
  assign accept_s  = MACDataValid && MACReady;

  // Control FSM, block/period counters and registered Tx outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r          <= S_OFF;
      gen_q_r          <= 3'd0;
      beat_cnt_r       <= 5'd0;
      block_cnt_r      <= 5'd0;
      TxData           <= 32'h0000_0000;
      TxDataK          <= 4'h0;
      TxDataValid      <= 1'b0;
      TxStartBlock     <= 1'b0;
      TxSyncHeader     <= 2'b00;
      TxElectricalIdle <= 1'b0;
    end else begin
      gen_q_r          <= GEN;
      TxElectricalIdle <= MACElectricalIdle;
      if (gen_chg_s) begin
        // Old-rate data is dropped so nothing wider than the new W survives.
        state_r      <= gen_state_f(GEN);
        beat_cnt_r   <= 5'd0;
        block_cnt_r  <= 5'd0;
        TxData       <= 32'h0000_0000;
        TxDataK      <= 4'h0;
        TxDataValid  <= 1'b0;
        TxStartBlock <= 1'b0;
        TxSyncHeader <= 2'b00;
      end else if (MACElectricalIdle) begin
        beat_cnt_r   <= 5'd0;
        block_cnt_r  <= 5'd0;
        TxDataValid  <= 1'b0;
        TxStartBlock <= 1'b0;
        TxSyncHeader <= 2'b00;
        if (state_r == S_STALL) begin
          state_r <= S_130;
        end else begin
          state_r <= state_r;
        end
      end else begin
        case (state_r)
          S_OFF: begin
            TxData       <= 32'h0000_0000;
            TxDataK      <= 4'h0;
            TxDataValid  <= 1'b0;
            TxStartBlock <= 1'b0;
            TxSyncHeader <= 2'b00;
          end
          S_8B: begin
            TxStartBlock <= 1'b0;
            TxSyncHeader <= 2'b00;
            if (accept_s) begin
              TxData      <= MACData & data_mask_s;
              TxDataK     <= MACDataK & k_mask_s;
              TxDataValid <= 1'b1;
            end else begin
              TxDataValid <= 1'b0;
            end
          end
          S_130: begin
            if (accept_s) begin
              TxData       <= MACData & data_mask_s;
              TxDataK      <= 4'h0;
              TxDataValid  <= 1'b1;
              TxStartBlock <= (beat_cnt_r == 5'd0);
              TxSyncHeader <= (beat_cnt_r == 5'd0) ? MACSyncHeader : 2'b00;
              if (beat_cnt_r == last_beat_s) begin
                beat_cnt_r <= 5'd0;
                if (block_cnt_r == last_block_s) begin
                  block_cnt_r <= 5'd0;
                  state_r     <= S_STALL;
                end else begin
                  block_cnt_r <= block_cnt_r + 5'd1;
                end
              end else begin
                beat_cnt_r <= beat_cnt_r + 5'd1;
              end
            end else begin
              TxDataValid  <= 1'b0;
              TxStartBlock <= 1'b0;
              TxSyncHeader <= 2'b00;
            end
          end
          S_STALL: begin
            TxDataValid  <= 1'b0;
            TxStartBlock <= 1'b0;
            TxSyncHeader <= 2'b00;
            state_r      <= S_130;
          end
          default: begin
            state_r      <= S_OFF;
            TxData       <= 32'h0000_0000;
            TxDataK      <= 4'h0;
            TxDataValid  <= 1'b0;
            TxStartBlock <= 1'b0;
            TxSyncHeader <= 2'b00;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_tx_data.sv
// Bench for pipe_tx_data: directed scenarios plus random traffic, checked
// against a model that counts accepted beats modulo the 64-beat stall period.
module tb_pipe_tx_data;

  localparam int G1W = 8;
  localparam int G2W = 16;
  localparam int G3W = 32;
  localparam int G4W = 8;
  localparam int G5W = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  GEN;
  logic [31:0] MACData;
  logic [3:0]  MACDataK;
  logic        MACDataValid;
  logic [1:0]  MACSyncHeader;
  logic        MACElectricalIdle;
  logic        MACReady;
  logic [31:0] TxData;
  logic [3:0]  TxDataK;
  logic        TxDataValid;
  logic        TxStartBlock;
  logic [1:0]  TxSyncHeader;
  logic        TxElectricalIdle;
  logic [5:0]  PIPEWIDTH;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: rate seen last cycle, beats accepted in the current period,
  // and whether the gearbox gap is due on the coming cycle.
  logic [2:0] gen_prev;
  int         acc_cnt;
  logic       stall_pend;

  pipe_tx_data #(
    .GEN1_PIPEWIDTH(G1W), .GEN2_PIPEWIDTH(G2W), .GEN3_PIPEWIDTH(G3W),
    .GEN4_PIPEWIDTH(G4W), .GEN5_PIPEWIDTH(G5W)
  ) dut (
    .clk(clk), .reset(reset), .GEN(GEN), .MACData(MACData), .MACDataK(MACDataK),
    .MACDataValid(MACDataValid), .MACSyncHeader(MACSyncHeader),
    .MACElectricalIdle(MACElectricalIdle), .MACReady(MACReady), .TxData(TxData),
    .TxDataK(TxDataK), .TxDataValid(TxDataValid), .TxStartBlock(TxStartBlock),
    .TxSyncHeader(TxSyncHeader), .TxElectricalIdle(TxElectricalIdle),
    .PIPEWIDTH(PIPEWIDTH)
  );

  always #5 clk = ~clk;

  function automatic int width_of(input logic [2:0] g);
    case (g)
      3'd1:    return G1W;
      3'd2:    return G2W;
      3'd3:    return G3W;
      3'd4:    return G4W;
      3'd5:    return G5W;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"}, TxData, 32'h0);
    chk({tag, "_k"}, {28'h0, TxDataK}, 32'h0);
    chk({tag, "_valid"}, {31'h0, TxDataValid}, 32'h0);
    chk({tag, "_start"}, {31'h0, TxStartBlock}, 32'h0);
    chk({tag, "_sync"}, {30'h0, TxSyncHeader}, 32'h0);
    chk({tag, "_idle"}, {31'h0, TxElectricalIdle}, 32'h0);
    chk({tag, "_ready"}, {31'h0, MACReady}, 32'h0);
  endtask

  // One clock: check combinational outputs, predict, clock, check registers.
  task automatic step();
    int w;
    int blk;
    logic gchg, rdy, chkd;
    logic [31:0] mask, e_data;
    logic [3:0] km, e_k;
    logic e_valid, e_sb, e_idle;
    logic [1:0] e_sh;
    #1;
    w    = width_of(GEN);
    gchg = (GEN != gen_prev);
    rdy  = !gchg && !MACElectricalIdle && !stall_pend && (w != 0);
    chk("pipewidth", {26'h0, PIPEWIDTH}, 32'(w));
    chk("macready", {31'h0, MACReady}, {31'h0, rdy});
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    km   = 4'((5'd1 << (w / 8)) - 5'd1);
    e_data = 32'h0; e_k = 4'h0; e_valid = 1'b0; e_sb = 1'b0; e_sh = 2'b00; chkd = 1'b0;
    if (gchg) begin
      acc_cnt = 0; stall_pend = 1'b0;
    end else if (MACElectricalIdle) begin
      acc_cnt = 0; stall_pend = 1'b0;
    end else if (stall_pend) begin
      stall_pend = 1'b0;
    end else if (w == 0) begin
      chkd = 1'b1;
    end else if (MACDataValid) begin
      e_valid = 1'b1;
      chkd    = 1'b1;
      e_data  = MACData & mask;
      if (GEN <= 3'd2) begin
        e_k = MACDataK & km;
      end else begin
        blk  = 128 / w;
        e_sb = ((acc_cnt % blk) == 0);
        e_sh = e_sb ? MACSyncHeader : 2'b00;
        acc_cnt++;
        if (acc_cnt == 64) begin
          acc_cnt = 0; stall_pend = 1'b1;
        end
      end
    end
    e_idle   = MACElectricalIdle;
    gen_prev = GEN;
    @(posedge clk);
    #1;
    chk("txvalid", {31'h0, TxDataValid}, {31'h0, e_valid});
    chk("txstart", {31'h0, TxStartBlock}, {31'h0, e_sb});
    chk("txsync", {30'h0, TxSyncHeader}, {30'h0, e_sh});
    chk("txidle", {31'h0, TxElectricalIdle}, {31'h0, e_idle});
    if (chkd) begin
      chk("txdata", TxData, e_data);
      chk("txdatak", {28'h0, TxDataK}, {28'h0, e_k});
    end
  endtask

  task automatic drive(input logic [2:0] g, input logic v, input logic idle);
    GEN = g;
    MACDataValid = v;
    MACElectricalIdle = idle;
    MACData = $urandom;
    MACDataK = 4'($urandom);
    MACSyncHeader = 2'($urandom);
    step();
  endtask

  task automatic run(input int n, input logic [2:0] g);
    for (int i = 0; i < n; i++) drive(g, 1'b1, 1'b0);
  endtask

  task automatic pulse_reset();
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    gen_prev = 3'd0; acc_cnt = 0; stall_pend = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    GEN = 3'd1;
    MACData = 32'h0; MACDataK = 4'h0; MACDataValid = 1'b0;
    MACSyncHeader = 2'b00; MACElectricalIdle = 1'b0;
    gen_prev = 3'd0; acc_cnt = 0; stall_pend = 1'b0;
    #1;
    chk_all_zero("reset");
    chk("reset_pipewidth", {26'h0, PIPEWIDTH}, 32'd8);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Gen1 directed beat, then random Gen1 traffic.
    drive(3'd1, 1'b1, 1'b0);
    GEN = 3'd1; MACData = 32'hA5A5_A5BC; MACDataK = 4'hF; MACDataValid = 1'b1;
    step();
    chk("gen1_data", TxData, 32'h0000_00BC);
    chk("gen1_k", {28'h0, TxDataK}, 32'h1);
    run(20, 3'd1);
    run(20, 3'd2);

    // Gen3 and Gen4 continuous streaming across a full stall period.
    run(140, 3'd3);
    run(150, 3'd4);

    // Gen3 mid-block gap of 3 cycles after beats 0 and 1.
    run(3, 3'd3);
    for (int i = 0; i < 3; i++) drive(3'd3, 1'b0, 1'b0);
    run(10, 3'd3);

    // Electrical idle in the middle of a stall period.
    run(30, 3'd3);
    for (int i = 0; i < 4; i++) drive(3'd3, 1'b1, 1'b1);
    run(100, 3'd3);

    // Rate changes mid-block, invalid rate, async reset mid-block.
    run(10, 3'd1);
    run(5, 3'd6);
    run(10, 3'd3);
    pulse_reset();
    run(80, 3'd3);
    run(20, 3'd5);

    // Random traffic with rate changes, gaps and idle.
    begin
      logic [2:0] g;
      g = 3'd3;
      for (int i = 0; i < 800; i++) begin
        if ($urandom_range(0, 99) < 3) g = 3'($urandom_range(0, 7));
        drive(g, ($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 4));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
